// File: rtl/pipe_stage.sv
// Valid/ready pipeline register carrying an instruction plus opaque payload, with
// flush-to-bubble and a saturating stall counter. Define PIPE_SKID_EN for the
// two-entry skid build with a registered in_ready.
module pipe_stage #(
   parameter int unsigned       INST_W    = 32,
   parameter int unsigned       PAYLOAD_W = 64,
   parameter logic [INST_W-1:0] NOP_INST  = INST_W'(32'h0000_0013),
   parameter int unsigned       CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INST_W-1:0]    in_inst,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INST_W-1:0]    out_inst,
   output logic [PAYLOAD_W-1:0] out_payload,
   input  logic                 flush,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam logic [CNT_W-1:0]     CNT_MAX      = {CNT_W{1'b1}};
   localparam logic [PAYLOAD_W-1:0] PAYLOAD_ZERO = {PAYLOAD_W{1'b0}};

   logic                 main_v_q, main_v_d;
   logic [INST_W-1:0]    main_inst_q, main_inst_d;
   logic [PAYLOAD_W-1:0] main_payload_q, main_payload_d;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
   logic                 emit;
   logic                 xfer;

`ifdef PIPE_SKID_EN
   logic                 skid_v_q, skid_v_d;
   logic [INST_W-1:0]    skid_inst_q, skid_inst_d;
   logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;

   assign in_ready = ~skid_v_q;
`else
   assign in_ready = ~main_v_q | out_ready;
`endif

   assign emit = main_v_q & out_ready;
   assign xfer = in_valid & in_ready;

   // The main register always holds NOP_INST / zero payload while empty, so the
   // outputs are taken straight from flops.
   always_comb begin
      main_v_d       = main_v_q;
      main_inst_d    = main_inst_q;
      main_payload_d = main_payload_q;
`ifdef PIPE_SKID_EN
      skid_v_d       = skid_v_q;
      skid_inst_d    = skid_inst_q;
      skid_payload_d = skid_payload_q;
`endif
      if (flush) begin
         main_v_d       = 1'b0;
         main_inst_d    = NOP_INST;
         main_payload_d = PAYLOAD_ZERO;
`ifdef PIPE_SKID_EN
         skid_v_d       = 1'b0;
`endif
      end else if (emit | ~main_v_q) begin
`ifdef PIPE_SKID_EN
         // Skid contents are older than anything on the input, so they go first.
         if (skid_v_q) begin
            main_v_d       = 1'b1;
            main_inst_d    = skid_inst_q;
            main_payload_d = skid_payload_q;
            skid_v_d       = 1'b0;
         end else if (xfer) begin
            main_v_d       = 1'b1;
            main_inst_d    = in_inst;
            main_payload_d = in_payload;
         end else begin
            main_v_d       = 1'b0;
            main_inst_d    = NOP_INST;
            main_payload_d = PAYLOAD_ZERO;
         end
`else
         if (xfer) begin
            main_v_d       = 1'b1;
            main_inst_d    = in_inst;
            main_payload_d = in_payload;
         end else begin
            main_v_d       = 1'b0;
            main_inst_d    = NOP_INST;
            main_payload_d = PAYLOAD_ZERO;
         end
`endif
      end else begin
`ifdef PIPE_SKID_EN
         if (xfer) begin
            skid_v_d       = 1'b1;
            skid_inst_d    = in_inst;
            skid_payload_d = in_payload;
         end else begin
            skid_v_d       = skid_v_q;
         end
`else
         main_v_d = main_v_q;
`endif
      end
   end

   // Stall counter: counts blocked output cycles, saturates, ignores flush.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_v_q & ~out_ready & (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_v_q       <= 1'b0;
         main_inst_q    <= NOP_INST;
         main_payload_q <= PAYLOAD_ZERO;
         stall_cnt_q    <= {CNT_W{1'b0}};
`ifdef PIPE_SKID_EN
         skid_v_q       <= 1'b0;
         skid_inst_q    <= NOP_INST;
         skid_payload_q <= PAYLOAD_ZERO;
`endif
      end else begin
         main_v_q       <= main_v_d;
         main_inst_q    <= main_inst_d;
         main_payload_q <= main_payload_d;
         stall_cnt_q    <= stall_cnt_d;
`ifdef PIPE_SKID_EN
         skid_v_q       <= skid_v_d;
         skid_inst_q    <= skid_inst_d;
         skid_payload_q <= skid_payload_d;
`endif
      end
   end

   assign out_valid   = main_v_q;
   assign out_inst    = main_inst_q;
   assign out_payload = main_payload_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: a FIFO-queue reference model checked every cycle,
// plus literal expectations for reset, streaming, back-pressure, flush and saturation.
module tb_pipe_stage;

   localparam int          CW  = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_SKID_EN
   localparam int          CAP = 2;
`else
   localparam int          CAP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_inst = 32'h0;
   logic [63:0]   in_payload = 64'h0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_inst;
   logic [63:0]   out_payload;
   logic          flush = 1'b0;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   pipe_stage #(.INST_W(32), .PAYLOAD_W(64), .NOP_INST(NOP), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_payload(in_payload),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_payload(out_payload),
      .flush(flush), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: the stage is a FIFO of capacity CAP.
   logic [31:0] mq_inst[$];
   logic [63:0] mq_pay[$];
   int          mcnt = 0;
   bit          m_init = 0;
   logic [31:0] elog[$];

   function automatic bit m_in_ready();
`ifdef PIPE_SKID_EN
      return mq_inst.size() < CAP;
`else
      return (mq_inst.size() == 0) || out_ready;
`endif
   endfunction

   always @(posedge clk) begin
      bit mir;
      bit m_emit;
      bit m_xfer;
      mir = m_in_ready();
      if (rst) begin
         mq_inst.delete();
         mq_pay.delete();
         mcnt = 0;
         m_init = 1;
      end else begin
         if (mq_inst.size() > 0 && !out_ready && mcnt != (1 << CW) - 1) mcnt++;
         if (flush) begin
            mq_inst.delete();
            mq_pay.delete();
         end else begin
            m_emit = (mq_inst.size() > 0) && out_ready;
            m_xfer = in_valid && mir;
            if (m_emit) begin
               void'(mq_inst.pop_front());
               void'(mq_pay.pop_front());
            end
            if (m_xfer) begin
               mq_inst.push_back(in_inst);
               mq_pay.push_back(in_payload);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, plus a log of what the DUT emits.
   always @(negedge clk) begin
      if (m_init) begin
         chk("out_valid", 64'(out_valid), 64'(mq_inst.size() > 0));
         chk("out_inst", 64'(out_inst), 64'(mq_inst.size() > 0 ? mq_inst[0] : NOP));
         chk("out_payload", out_payload, mq_pay.size() > 0 ? mq_pay[0] : 64'h0);
         chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
         chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
         if (out_valid && out_ready && !rst && !flush) elog.push_back(out_inst);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [31:0] inst);
      in_inst    = inst;
      in_payload = {inst, ~inst};
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] s[3];
      bit          xf;
      s[0] = 32'h00A0_0093;
      s[1] = 32'h00B0_0113;
      s[2] = 32'h0020_81B3;

      // Reset then idle
      do_reset(2);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_inst", 64'(out_inst), 64'h0000_0013);
      chk("rst_out_payload", out_payload, 64'h0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      tick();

      // Streaming
      elog.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         set_in(s[i]);
         tick();
         chk("stream_inst", 64'(out_inst), 64'(s[i]));
         if (i == 0) chk("stream_payload", out_payload, 64'h00A0_0093_FF5F_FF6C);
      end
      in_valid = 1'b0;
      repeat (3) tick();
      chk("stream_count", 64'(elog.size()), 64'd3);
      for (int i = 0; i < 3 && i < elog.size(); i++) chk("stream_order", 64'(elog[i]), 64'(s[i]));

      // Back-pressure
      do_reset(1);
      elog.delete();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_in(s[0]);
      tick();
      set_in(s[1]);
      for (int i = 0; i < 5; i++) begin
         xf = in_valid && m_in_ready();
         tick();
         if (xf) in_valid = 1'b0;
      end
      chk("bp_stall_cnt", 64'(stall_cnt), 64'd5);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 4 && in_valid; i++) begin
         xf = m_in_ready();
         tick();
         if (xf) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      repeat (3) tick();
      chk("bp_count", 64'(elog.size()), 64'd2);
      for (int i = 0; i < 2 && i < elog.size(); i++) chk("bp_order", 64'(elog[i]), 64'(s[i]));

      // Flush with simultaneous transfer while full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_in(32'h0010_0293);
      tick();
      set_in(32'h0020_0313);
      tick();
      flush = 1'b1;
      set_in(32'h00C0_0193);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'h0);
      chk("flush_out_inst", 64'(out_inst), 64'h0000_0013);
      elog.delete();
      out_ready = 1'b1;
      repeat (4) tick();
      chk("flush_no_emit", 64'(elog.size()), 64'd0);

      // Counter saturation
      do_reset(1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_in(s[2]);
      tick();
      in_valid = 1'b0;
      repeat (20) tick();
      chk("sat_stall_cnt", 64'(stall_cnt), 64'd15);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("sat_after_flush", 64'(stall_cnt), 64'd15);
      do_reset(1);
      chk("sat_after_rst", 64'(stall_cnt), 64'd0);

      // Reset mid-operation
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_in(32'h0030_0393);
      tick();
      set_in(32'h0040_0413);
      tick();
      out_ready = 1'b1;
      set_in(32'h0050_0493);
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("midrst_out_valid", 64'(out_valid), 64'h0);
      chk("midrst_out_inst", 64'(out_inst), 64'h0000_0013);
      chk("midrst_payload", out_payload, 64'h0);
      chk("midrst_in_ready", 64'(in_ready), 64'h1);
      elog.delete();
      repeat (4) tick();
      chk("midrst_no_stale", 64'(elog.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
